// File: rtl/bloons_pkg.sv
// Shared constants and types for the tower-defence money ledger.
// Module parameters default to these values; the typedefs match the defaults.
package bloons_pkg;

  localparam int N_BLOONS    = 32;
  localparam int N_MONKEYS   = 8;
  localparam int MONEY_W     = 12;
  localparam int COST_W      = 10;
  localparam int START_MONEY = 400;
  localparam int POP_REWARD  = 10;
  localparam int ROUND_BONUS = 100;
  localparam int MONEY_MAX   = 4095;

  typedef logic [MONEY_W-1:0]           money_t;
  typedef logic [COST_W-1:0]            cost_t;
  typedef logic [$clog2(N_MONKEYS)-1:0] slot_idx_t;

endpackage

// File: rtl/buy_arbiter.sv
// Combinational purchase arbiter: the lowest-index candidate wins, and it is
// then checked against the registered balance.
module buy_arbiter
  import bloons_pkg::*;
#(
  parameter int N       = N_MONKEYS,
  parameter int C_W     = COST_W,
  parameter int M_W     = MONEY_W,
  parameter int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]          cand,
  input  logic [N-1:0][C_W-1:0] costs,
  input  logic [M_W-1:0]        balance,
  output logic                  valid,
  output logic [IDX_W-1:0]      idx,
  output logic                  affordable,
  output logic [C_W-1:0]        cost
);

  localparam int CMP_W = M_W + C_W;

  // Scan downwards so the last assignment is the lowest set index.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

  assign cost       = costs[idx];
  assign affordable = valid && (CMP_W'(cost) <= CMP_W'(balance));

endmodule

// File: rtl/money_ledger.sv
// Player-money ledger: pop/bonus/refund income, purchase arbitration with an
// affordability check, per-slot ownership and a saturating balance.
module money_ledger
  import bloons_pkg::*;
#(
  parameter int NB      = N_BLOONS,
  parameter int NM      = N_MONKEYS,
  parameter int M_W     = MONEY_W,
  parameter int C_W     = COST_W,
  parameter int START   = START_MONEY,
  parameter int POP_REW = POP_REWARD,
  parameter int BONUS   = ROUND_BONUS,
  parameter int MAX_BAL = MONEY_MAX,
  parameter int IDX_W   = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic                   Clk,
  input  logic                   reset_n,
  input  logic                   game_restart,
  input  logic [NB-1:0]          bloon_popped,
  input  logic                   round_done,
  input  logic [NM-1:0]          buy_req,
  input  logic [NM-1:0][C_W-1:0] buy_cost,
  input  logic                   sell_valid,
  input  logic [IDX_W-1:0]       sell_slot,
  output logic [M_W-1:0]         money_out,
  output logic [NM-1:0]          owned,
  output logic [NM-1:0]          buy_grant,
  output logic [NM-1:0]          buy_deny,
  output logic                   sat_flag
);

  localparam int ACC_W  = M_W + 2;
  localparam int PCNT_W = $clog2(NB + 1);

  logic [NB-1:0]          hist;
  logic [NM-1:0][C_W-1:0] paid_cost;

  logic [NB-1:0]     new_pops;
  logic [PCNT_W-1:0] pop_cnt;
  logic              sell_hit;
  logic [C_W-1:0]    refund;
  logic [ACC_W-1:0]  income;
  logic [ACC_W-1:0]  spend;
  logic [ACC_W-1:0]  next_bal;
  logic              clip;

  logic              arb_valid;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_afford;
  logic [C_W-1:0]    arb_cost;
  logic              grant_now;

  assign new_pops = bloon_popped & ~hist;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < NB; i++) begin
      pop_cnt = pop_cnt + PCNT_W'(new_pops[i]);
    end
  end

  buy_arbiter #(
    .N     (NM),
    .C_W   (C_W),
    .M_W   (M_W),
    .IDX_W (IDX_W)
  ) u_buy_arbiter (
    .cand       (buy_req & ~owned),
    .costs      (buy_cost),
    .balance    (money_out),
    .valid      (arb_valid),
    .idx        (arb_idx),
    .affordable (arb_afford),
    .cost       (arb_cost)
  );

  assign grant_now = arb_valid && arb_afford;

  // A slot under arbitration is never owned, so a sell can never collide with a grant.
  assign sell_hit = sell_valid && owned[sell_slot];
  assign refund   = sell_hit ? (paid_cost[sell_slot] >> 1) : '0;

  assign income   = ACC_W'(pop_cnt) * ACC_W'(POP_REW)
                  + (round_done ? ACC_W'(BONUS) : '0)
                  + ACC_W'(refund);
  assign spend    = grant_now ? ACC_W'(arb_cost) : '0;
  assign next_bal = ACC_W'(money_out) + income - spend;
  assign clip     = next_bal > ACC_W'(MAX_BAL);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      money_out <= M_W'(START);
      owned     <= '0;
      paid_cost <= '0;
      buy_grant <= '0;
      buy_deny  <= '0;
      sat_flag  <= 1'b0;
      hist      <= '0;
    end else if (game_restart) begin
      money_out <= M_W'(START);
      owned     <= '0;
      paid_cost <= '0;
      buy_grant <= '0;
      buy_deny  <= '0;
      sat_flag  <= 1'b0;
      hist      <= bloon_popped;
    end else begin
      hist      <= bloon_popped;
      buy_grant <= '0;
      buy_deny  <= '0;
      money_out <= clip ? M_W'(MAX_BAL) : next_bal[M_W-1:0];
      if (clip) begin
        sat_flag <= 1'b1;
      end
      if (sell_hit) begin
        owned[sell_slot] <= 1'b0;
      end
      if (arb_valid) begin
        if (arb_afford) begin
          buy_grant[arb_idx] <= 1'b1;
          owned[arb_idx]     <= 1'b1;
          paid_cost[arb_idx] <= arb_cost;
        end else begin
          buy_deny[arb_idx]  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_money_ledger.sv
// Bench for money_ledger: directed scenarios plus a random phase, checked
// through a scoreboard fed by a cycle model of the ledger.
module tb_money_ledger;
  import bloons_pkg::*;

  logic                 Clk = 1'b0;
  logic                 reset_n;
  logic                 game_restart;
  logic [31:0]          bloon_popped;
  logic                 round_done;
  logic [7:0]           buy_req;
  logic [7:0][9:0]      buy_cost;
  logic                 sell_valid;
  logic [2:0]           sell_slot;
  logic [11:0]          money_out;
  logic [7:0]           owned;
  logic [7:0]           buy_grant;
  logic [7:0]           buy_deny;
  logic                 sat_flag;

  always #5 Clk = ~Clk;

  money_ledger dut (
    .Clk          (Clk),
    .reset_n      (reset_n),
    .game_restart (game_restart),
    .bloon_popped (bloon_popped),
    .round_done   (round_done),
    .buy_req      (buy_req),
    .buy_cost     (buy_cost),
    .sell_valid   (sell_valid),
    .sell_slot    (sell_slot),
    .money_out    (money_out),
    .owned        (owned),
    .buy_grant    (buy_grant),
    .buy_deny     (buy_deny),
    .sat_flag     (sat_flag)
  );

  typedef struct {
    int         money;
    logic [7:0] owned;
    logic [7:0] grant;
    logic [7:0] deny;
    logic       sat;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  int          m_money;
  logic [7:0]  m_owned;
  int          m_paid[8];
  logic [31:0] m_hist;
  logic        m_sat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input logic [31:0] h);
    m_money = 400;
    m_owned = '0;
    for (int i = 0; i < 8; i++) m_paid[i] = 0;
    m_sat  = 1'b0;
    m_hist = h;
  endtask

  // Model one clock edge from the inputs currently driven, queue the result,
  // then advance to the edge and compare against the DUT.
  task automatic step();
    exp_t e, got;
    int pops, income, spend, nm, idx;
    e.grant = '0;
    e.deny  = '0;
    if (game_restart) begin
      model_reset(bloon_popped);
    end else begin
      pops   = $countones(bloon_popped & ~m_hist);
      income = pops * 10 + (round_done ? 100 : 0);
      spend  = 0;
      idx    = -1;
      for (int i = 7; i >= 0; i--) if (buy_req[i] && !m_owned[i]) idx = i;
      if (sell_valid && m_owned[sell_slot]) begin
        income += m_paid[sell_slot] / 2;
        m_owned[sell_slot] = 1'b0;
      end
      if (idx >= 0) begin
        if (int'(buy_cost[idx]) <= m_money) begin
          e.grant[idx] = 1'b1;
          m_owned[idx] = 1'b1;
          m_paid[idx]  = int'(buy_cost[idx]);
          spend        = int'(buy_cost[idx]);
        end else begin
          e.deny[idx] = 1'b1;
        end
      end
      nm = m_money + income - spend;
      if (nm > 4095) begin
        nm    = 4095;
        m_sat = 1'b1;
      end
      m_money = nm;
      m_hist  = bloon_popped;
    end
    e.money = m_money;
    e.owned = m_owned;
    e.sat   = m_sat;
    sbq.push_back(e);
    @(posedge Clk);
    #1;
    got = sbq.pop_front();
    chk("money", 32'(money_out), 32'(got.money));
    chk("owned", 32'(owned),     32'(got.owned));
    chk("grant", 32'(buy_grant), 32'(got.grant));
    chk("deny",  32'(buy_deny),  32'(got.deny));
    chk("sat",   32'(sat_flag),  32'(got.sat));
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    game_restart = 1'b0;
    bloon_popped = '0;
    round_done   = 1'b0;
    buy_req      = '0;
    buy_cost     = '0;
    sell_valid   = 1'b0;
    sell_slot    = '0;
    model_reset('0);
    #23;
    chk("rst_money", 32'(money_out), 400);
    chk("rst_owned", 32'(owned), 0);
    chk("rst_grant", 32'(buy_grant | buy_deny), 0);
    chk("rst_sat",   32'(sat_flag), 0);
    @(negedge Clk);
    reset_n = 1'b1;
    @(negedge Clk);

    // three simultaneous pops, then held high
    bloon_popped = 32'h8000_0021;
    step();
    chk("pop3", 32'(money_out), 430);
    for (int i = 0; i < 10; i++) step();
    chk("pop_held", 32'(money_out), 430);

    // two requesters at 250 with 430 in the bank
    buy_req     = 8'b0010_0100;
    buy_cost[2] = 10'd250;
    buy_cost[5] = 10'd250;
    step();
    chk("grant2", 32'(buy_grant), 32'h04);
    chk("buy_money", 32'(money_out), 180);
    step();
    chk("deny5", 32'(buy_deny), 32'h20);
    step();
    chk("deny5_again", 32'(buy_deny), 32'h20);
    buy_req = '0;

    // sell slot 2 together with a round bonus
    sell_valid = 1'b1;
    sell_slot  = 3'd2;
    round_done = 1'b1;
    step();
    chk("sell_money", 32'(money_out), 405);
    chk("sell_owned", 32'(owned[2]), 0);
    round_done = 1'b0;
    sell_slot  = 3'd6;
    step();
    chk("sell_unowned", 32'(money_out), 405);
    sell_valid = 1'b0;

    // climb to 4090, then overflow by 5 pops
    game_restart = 1'b1;
    bloon_popped = '0;
    step();
    game_restart = 1'b0;
    round_done   = 1'b1;
    for (int i = 0; i < 36; i++) step();
    round_done   = 1'b0;
    bloon_popped = 32'h0000_01FF;
    step();
    chk("pre_sat", 32'(money_out), 4090);
    bloon_popped = 32'h0000_3FFF;
    step();
    chk("sat_money", 32'(money_out), 4095);
    chk("sat_set", 32'(sat_flag), 1);
    for (int i = 0; i < 3; i++) step();
    chk("sat_sticky", 32'(sat_flag), 1);

    // exact-balance purchase with a pop on the same cycle
    game_restart = 1'b1;
    step();
    game_restart = 1'b0;
    chk("restart_sat", 32'(sat_flag), 0);
    buy_req      = 8'b0000_1000;
    buy_cost[3]  = 10'd400;
    bloon_popped = 32'h0000_7FFF;
    step();
    chk("grant3", 32'(buy_grant), 32'h08);
    chk("exact_money", 32'(money_out), 10);
    buy_req = '0;

    // async reset with an affordable request pending
    buy_req      = 8'b0001_0000;
    buy_cost[4]  = 10'd5;
    bloon_popped = '0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_money", 32'(money_out), 400);
    chk("arst_owned", 32'(owned), 0);
    chk("arst_pulses", 32'(buy_grant | buy_deny), 0);
    chk("arst_sat", 32'(sat_flag), 0);
    model_reset('0);
    @(negedge Clk);
    buy_req = '0;
    reset_n = 1'b1;
    step();
    chk("arst_nogrant", 32'(buy_grant), 0);

    // restart with every bloon high
    round_done = 1'b1;
    step();
    round_done   = 1'b0;
    game_restart = 1'b1;
    bloon_popped = '1;
    step();
    chk("rs_money", 32'(money_out), 400);
    game_restart = 1'b0;
    step();
    chk("rs_after", 32'(money_out), 400);

    // random traffic against the model
    for (int n = 0; n < 80; n++) begin
      bloon_popped = bloon_popped ^ ($urandom & $urandom & $urandom);
      round_done   = ($urandom_range(0, 7) == 0);
      buy_req      = 8'($urandom & $urandom);
      for (int s = 0; s < 8; s++) buy_cost[s] = 10'($urandom_range(0, 1023));
      sell_valid   = ($urandom_range(0, 3) == 0);
      sell_slot    = 3'($urandom_range(0, 7));
      game_restart = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
